dcache_miss_ctrl: RTL and testbench
===================================

# dcache_miss_ctrl

Non-speculative miss/uncached sequencer for the data cache. It sits behind commit and owns dcache SRAM port 1 while busy. On a committed cacheable miss it writes back the dirty victim line, refills the line from the bus, and writes data and tag. On an uncached access it performs a single-beat bus transaction. It then returns one response to commit.

## Interface
- `LINE_WORDS`, default 4: words per cache line. Fixed at 4: 16-byte line, `paddr[3:2]` is the word index.
- `WAY_NUM`, default 2: ways. The way select is one-hot.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous active-low.
- `req_valid_i` / `req_ready_o` in / out 1 / 1: request handshake from commit.
- `req_paddr_i` in 32: access address.
- `req_way_i` in WAY_NUM: one-hot victim (refill) way.
- `req_dirty_i` in 1: victim line is dirty.
- `req_victim_addr_i` in 32: victim line address. Bits [3:0] are ignored.
- `req_uncached_i`, `req_store_i` in 1: access type.
- `req_wdata_i` in 32, `req_strb_i` in 4: store data and byte enables.
- `resp_valid_o` out 1, `resp_rdata_o` out 32: completion pulse and load data.
- `cache_addr_o` out 32, `cache_way_o` out WAY_NUM: SRAM port-1 address and way.
- `cache_strb_o` out 4, `cache_wdata_o` out 32: data SRAM write.
- `cache_tag_we_o` out 1, `cache_tag_data_o` out `$bits(cache_tag_t)`: tag write.
- `cache_rdata_i` in 32: port-1 read data for `cache_way_o`, valid one cycle after the address.
- `rd_req_o` / `rd_ready_i` out / in 1 / 1: bus read-address handshake.
- `rd_addr_o` out 32, `rd_len_o` out 2: beats−1.
- `rd_valid_i` in 1, `rd_data_i` in 32, `rd_last_i` in 1: bus read beats. There is no back-pressure on beats.
- `wr_req_o` / `wr_ready_i` out / in 1 / 1: bus write-address handshake.
- `wr_addr_o` out 32, `wr_len_o` out 2: write address and beats−1.
- `wr_data_valid_o` / `wr_data_ready_i` out / in 1 / 1: bus write-data handshake.
- `wr_data_o` out 32, `wr_strb_o` out 4, `wr_last_o` out 1: write-data beat contents.
- `wr_done_i` in 1: write response.

## Operation
- The FSM states are IDLE, WB_RD, WB_ADDR, WB_DATA, WB_WAIT, RF_ADDR, RF_DATA, RF_TAG, UC_ADDR, UC_DATA, UC_WAIT and RESP.
- `req_ready_o` = (state==IDLE). On accept, all `req_*` fields are latched.
- IDLE dispatch:
  - uncached load → UC_ADDR;
  - uncached store → UC_ADDR;
  - cached with `req_dirty_i` → WB_RD;
  - otherwise → RF_ADDR.
- WB_RD: for 4 cycles drive `cache_addr_o`={victim[31:4],k,2'b00}, with k counting 0..3 and `cache_way_o`=way. Capture `cache_rdata_i` one cycle later into line buffer entry k. After the 4th capture, go to WB_ADDR.
- WB_ADDR: `wr_req_o`=1, `wr_addr_o`={victim[31:4],4'b0}, `wr_len_o`=3. On `wr_ready_i` → WB_DATA.
- WB_DATA: send buffer entries 0..3 with strb 4'hF. Each beat advances on `wr_data_ready_i`. `wr_last_o` is high on entry 3. After the last beat → WB_WAIT.
- WB_WAIT: on `wr_done_i` → RF_ADDR.
- RF_ADDR: `rd_req_o`=1, `rd_addr_o`={paddr[31:4],4'b0}, `rd_len_o`=3. On `rd_ready_i` → RF_DATA.
- RF_DATA: each `rd_valid_i` beat k is written in the same cycle to the data SRAM: address {paddr[31:4],k,2'b00}, `cache_strb_o`=4'hF, way=latched way.
  - If k==paddr[3:2] and the access is a store, `cache_wdata_o` is the bus word merged with `req_wdata` per strb.
  - If the access is a load, that beat is captured as load data.
  - `rd_last_i` → RF_TAG. A premature or missing `rd_last_i` is a bus protocol violation and is not checked.
- RF_TAG: one cycle with `cache_tag_we_o`=1 and tag={tag:paddr[31:12], v:1, d:store}. Then → RESP.
- UC_ADDR:
  - Load: `rd_req_o`, `rd_len_o`=0, address=paddr. Then UC_DATA captures the single beat and goes to RESP.
  - Store: `wr_req_o`, `wr_len_o`=0. Then UC_DATA sends one beat with `req_strb`, `wr_last_o`=1. Then UC_WAIT waits for `wr_done_i` and goes to RESP.
- RESP: `resp_valid_o`=1 for exactly one cycle. `resp_rdata_o` holds the raw 32-bit word for loads and 0 for stores. Then → IDLE.
- In every state other than the port-1 write/read states, port-1 outputs are held inactive: way=0, strb=0, tag_we=0.
- There is no flush input. Requests are post-commit and always complete.

## Timing
- On reset, all outputs are 0. Reset asserted mid-transaction returns the FSM to IDLE and clears all outputs. The bus bridge is reset by the same `rst_n`.
- Minimum latency from accept to `resp_valid_o`, with zero-wait bus and `rd_ready_i`/`wr_ready_i` high:
  - clean refill: 1 (RF_ADDR) + 4 beats + 1 (RF_TAG) + 1 = 7 cycles;
  - dirty: +5 (WB_RD) + 1 + 4 + 1 (done) = 18 cycles;
  - uncached load: 3 cycles;
  - uncached store: 4 cycles.
- Bus request signals hold stable until their ready. Address and data never change while valid and not ready.
- `cache_rdata_i` is sampled exactly one cycle after its address was driven. Back-to-back WB_RD reads are pipelined.
- `req_ready_o` is low from the accept cycle through RESP. At most one request is outstanding.

## Structure
- Package `a_defines.svh` gains `dcache_ctrl_state_e` and bus length constants `_BUS_LEN_SINGLE`=2'd0 and `_BUS_LEN_LINE`=2'd3. `cache_tag_t` is reused unchanged.
- Sub-module `dcache_line_buf`: a 4×32 register file with a write index, a read index and a clear.

## Test plan
- Clean load miss: paddr 0x1C00_0048, way 2'b01, bus beats A0..A3 → four SRAM writes at 0x..40/44/48/4C, then tag write {0x1C000,v1,d0}, resp_rdata=A2 at cycle 7.
- Dirty store miss: victim 0x0800_1040, buffered SRAM words W0..W3; store 0xDEADBEEF strb 4'b0011 at word 1 → bus write of W0..W3 with last on beat 3; refill word 1 written as {B1[31:16],16'hBEEF}; tag d=1.
- Uncached store: paddr 0xBFAF_8000, strb 4'b1000 → single write beat with strb 8 and wr_last=1; resp only after wr_done_i.
- Back-pressure: wr_data_ready_i toggling 1-0-1 → data/strb/last stable while stalled, no beat lost or duplicated.
- Reset asserted during RF_DATA beat 2 → all outputs 0 the same cycle, req_ready_o=1 after release, next request completes normally.

Source files
------------

// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types and constants for the data-cache miss/uncached sequencer.
package dcache_miss_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WB_RD,
    WB_ADDR,
    WB_DATA,
    WB_WAIT,
    RF_ADDR,
    RF_DATA,
    RF_TAG,
    UC_ADDR,
    UC_DATA,
    UC_WAIT,
    RESP
  } dcache_ctrl_state_e;

  typedef struct packed {
    logic [19:0] tag;
    logic        v;
    logic        d;
  } cache_tag_t;

  localparam logic [1:0] _BUS_LEN_SINGLE = 2'd0;
  localparam logic [1:0] _BUS_LEN_LINE   = 2'd3;
  localparam int         WORD_W          = 32;

  function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] new_w,
                                                   input logic [3:0]        strb);
    logic [WORD_W-1:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_miss_ctrl_line_buf.sv
// Four-word victim line buffer: one write port, one combinational read port, clear.
module dcache_line_buf
  import dcache_miss_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [1:0]        widx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [1:0]        ridx_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [3:0][WORD_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (clr_i) begin
      mem_d = '0;
    end else if (we_i) begin
      mem_d[widx_i] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Post-commit miss/uncached sequencer: victim writeback, line refill, tag write,
// or a single-beat uncached bus access, followed by one response pulse.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int WAY_NUM    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [31:0]                   req_paddr_i,
  input  logic [WAY_NUM-1:0]            req_way_i,
  input  logic                          req_dirty_i,
  input  logic [31:0]                   req_victim_addr_i,
  input  logic                          req_uncached_i,
  input  logic                          req_store_i,
  input  logic [31:0]                   req_wdata_i,
  input  logic [3:0]                    req_strb_i,
  output logic                          resp_valid_o,
  output logic [31:0]                   resp_rdata_o,
  output logic [31:0]                   cache_addr_o,
  output logic [WAY_NUM-1:0]            cache_way_o,
  output logic [3:0]                    cache_strb_o,
  output logic [31:0]                   cache_wdata_o,
  output logic                          cache_tag_we_o,
  output logic [$bits(cache_tag_t)-1:0] cache_tag_data_o,
  input  logic [31:0]                   cache_rdata_i,
  output logic                          rd_req_o,
  input  logic                          rd_ready_i,
  output logic [31:0]                   rd_addr_o,
  output logic [1:0]                    rd_len_o,
  input  logic                          rd_valid_i,
  input  logic [31:0]                   rd_data_i,
  input  logic                          rd_last_i,
  output logic                          wr_req_o,
  input  logic                          wr_ready_i,
  output logic [31:0]                   wr_addr_o,
  output logic [1:0]                    wr_len_o,
  output logic                          wr_data_valid_o,
  input  logic                          wr_data_ready_i,
  output logic [31:0]                   wr_data_o,
  output logic [3:0]                    wr_strb_o,
  output logic                          wr_last_o,
  input  logic                          wr_done_i
);

  localparam logic [2:0] LINE_CNT = 3'(LINE_WORDS);
  localparam logic [2:0] LAST_IDX = LINE_CNT - 3'd1;

  dcache_ctrl_state_e state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               store_q, store_d;

  logic [31:0]        paddr_q, paddr_d;
  logic [WAY_NUM-1:0] way_q, way_d;
  logic [27:0]        victim_q, victim_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         strb_q, strb_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               lb_clr, lb_we;
  logic [1:0]         lb_widx;
  logic [31:0]        lb_rdata;
  cache_tag_t         tag_w;
  logic               victim_lsb_unused;

  // Victim line is always line aligned; its byte offset carries no information.
  assign victim_lsb_unused = ^req_victim_addr_i[3:0];

  dcache_line_buf u_line_buf (
    .clk     (clk),
    .clr_i   (lb_clr),
    .we_i    (lb_we),
    .widx_i  (lb_widx),
    .wdata_i (cache_rdata_i),
    .ridx_i  (cnt_q[1:0]),
    .rdata_o (lb_rdata)
  );

  assign req_ready_o = rst_n && (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    paddr_d  = paddr_q;
    way_d    = way_q;
    victim_d = victim_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    rdata_d  = rdata_q;

    lb_clr  = 1'b0;
    lb_we   = 1'b0;
    lb_widx = cnt_q[1:0] - 2'd1;

    tag_w.tag = paddr_q[31:12];
    tag_w.v   = 1'b1;
    tag_w.d   = store_q;

    resp_valid_o     = 1'b0;
    resp_rdata_o     = '0;
    cache_addr_o     = '0;
    cache_way_o      = '0;
    cache_strb_o     = '0;
    cache_wdata_o    = '0;
    cache_tag_we_o   = 1'b0;
    cache_tag_data_o = '0;
    rd_req_o         = 1'b0;
    rd_addr_o        = '0;
    rd_len_o         = '0;
    wr_req_o         = 1'b0;
    wr_addr_o        = '0;
    wr_len_o         = '0;
    wr_data_valid_o  = 1'b0;
    wr_data_o        = '0;
    wr_strb_o        = '0;
    wr_last_o        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          paddr_d  = req_paddr_i;
          way_d    = req_way_i;
          victim_d = req_victim_addr_i[31:4];
          store_d  = req_store_i;
          wdata_d  = req_wdata_i;
          strb_d   = req_strb_i;
          rdata_d  = '0;
          cnt_d    = '0;
          lb_clr   = 1'b1;
          if (req_uncached_i)   state_d = UC_ADDR;
          else if (req_dirty_i) state_d = WB_RD;
          else                  state_d = RF_ADDR;
        end
      end

      // Reads are issued on counts 0..3; each word lands one cycle later,
      // so capture runs on counts 1..4 into entry count-1.
      WB_RD: begin
        if (cnt_q < LINE_CNT) begin
          cache_addr_o = {victim_q, cnt_q[1:0], 2'b00};
          cache_way_o  = way_q;
        end
        lb_we = (cnt_q != 3'd0);
        if (cnt_q == LINE_CNT) begin
          cnt_d   = '0;
          state_d = WB_ADDR;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      WB_ADDR: begin
        wr_req_o  = 1'b1;
        wr_addr_o = {victim_q, 4'b0000};
        wr_len_o  = _BUS_LEN_LINE;
        if (wr_ready_i) state_d = WB_DATA;
      end

      WB_DATA: begin
        wr_data_valid_o = 1'b1;
        wr_data_o       = lb_rdata;
        wr_strb_o       = 4'hF;
        wr_last_o       = (cnt_q == LAST_IDX);
        if (wr_data_ready_i) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = WB_WAIT;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      WB_WAIT: begin
        if (wr_done_i) state_d = RF_ADDR;
      end

      RF_ADDR: begin
        rd_req_o  = 1'b1;
        rd_addr_o = {paddr_q[31:4], 4'b0000};
        rd_len_o  = _BUS_LEN_LINE;
        if (rd_ready_i) begin
          cnt_d   = '0;
          state_d = RF_DATA;
        end
      end

      // Each beat goes straight into the data SRAM; the accessed word is
      // merged with store data or captured as load data.
      RF_DATA: begin
        if (rd_valid_i) begin
          cache_addr_o  = {paddr_q[31:4], cnt_q[1:0], 2'b00};
          cache_way_o   = way_q;
          cache_strb_o  = 4'hF;
          cache_wdata_o = rd_data_i;
          if (cnt_q[1:0] == paddr_q[3:2]) begin
            if (store_q) cache_wdata_o = merge_word(rd_data_i, wdata_q, strb_q);
            else         rdata_d       = rd_data_i;
          end
          cnt_d = cnt_q + 3'd1;
          if (rd_last_i) begin
            cnt_d   = '0;
            state_d = RF_TAG;
          end
        end
      end

      RF_TAG: begin
        cache_addr_o     = {paddr_q[31:4], 4'b0000};
        cache_way_o      = way_q;
        cache_tag_we_o   = 1'b1;
        cache_tag_data_o = tag_w;
        state_d          = RESP;
      end

      UC_ADDR: begin
        if (store_q) begin
          wr_req_o  = 1'b1;
          wr_addr_o = paddr_q;
          wr_len_o  = _BUS_LEN_SINGLE;
          if (wr_ready_i) state_d = UC_DATA;
        end else begin
          rd_req_o  = 1'b1;
          rd_addr_o = paddr_q;
          rd_len_o  = _BUS_LEN_SINGLE;
          if (rd_ready_i) state_d = UC_DATA;
        end
      end

      UC_DATA: begin
        if (store_q) begin
          wr_data_valid_o = 1'b1;
          wr_data_o       = wdata_q;
          wr_strb_o       = strb_q;
          wr_last_o       = 1'b1;
          if (wr_data_ready_i) state_d = UC_WAIT;
        end else if (rd_valid_i) begin
          rdata_d = rd_data_i;
          state_d = RESP;
        end
      end

      UC_WAIT: begin
        if (wr_done_i) state_d = RESP;
      end

      RESP: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = store_q ? 32'h0 : rdata_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
    end
  end

  // Request payload and load data are only observed in states entered after
  // a fresh accept, so they need no reset.
  always_ff @(posedge clk) begin
    paddr_q  <= paddr_d;
    way_q    <= way_d;
    victim_q <= victim_d;
    wdata_q  <= wdata_d;
    strb_q   <= strb_d;
    rdata_q  <= rdata_d;
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: abstract bus/SRAM memories, randomized traffic.
module tb_dcache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o;
  logic [31:0] req_paddr_i, req_victim_addr_i, req_wdata_i;
  logic [1:0]  req_way_i;
  logic        req_dirty_i, req_uncached_i, req_store_i;
  logic [3:0]  req_strb_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o, cache_addr_o, cache_wdata_o, cache_rdata_i;
  logic [1:0]  cache_way_o;
  logic [3:0]  cache_strb_o;
  logic        cache_tag_we_o;
  logic [21:0] cache_tag_data_o;
  logic        rd_req_o, rd_ready_i, rd_valid_i, rd_last_i;
  logic [31:0] rd_addr_o, rd_data_i;
  logic [1:0]  rd_len_o;
  logic        wr_req_o, wr_ready_i, wr_data_valid_o, wr_data_ready_i, wr_last_o, wr_done_i;
  logic [31:0] wr_addr_o, wr_data_o;
  logic [1:0]  wr_len_o;
  logic [3:0]  wr_strb_o;

  dcache_miss_ctrl #(.LINE_WORDS(4), .WAY_NUM(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_paddr_i(req_paddr_i),
    .req_way_i(req_way_i), .req_dirty_i(req_dirty_i), .req_victim_addr_i(req_victim_addr_i),
    .req_uncached_i(req_uncached_i), .req_store_i(req_store_i), .req_wdata_i(req_wdata_i),
    .req_strb_i(req_strb_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .cache_addr_o(cache_addr_o), .cache_way_o(cache_way_o), .cache_strb_o(cache_strb_o),
    .cache_wdata_o(cache_wdata_o), .cache_tag_we_o(cache_tag_we_o),
    .cache_tag_data_o(cache_tag_data_o), .cache_rdata_i(cache_rdata_i),
    .rd_req_o(rd_req_o), .rd_ready_i(rd_ready_i), .rd_addr_o(rd_addr_o), .rd_len_o(rd_len_o),
    .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i), .rd_last_i(rd_last_i),
    .wr_req_o(wr_req_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o), .wr_len_o(wr_len_o),
    .wr_data_valid_o(wr_data_valid_o), .wr_data_ready_i(wr_data_ready_i),
    .wr_data_o(wr_data_o), .wr_strb_o(wr_strb_o), .wr_last_o(wr_last_o), .wr_done_i(wr_done_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  bit zero_wait = 1'b1;

  logic [31:0] bmem [logic [29:0]];
  logic [31:0] exp_resp[$];
  int          exp_lat[$];
  logic [65:0] exp_cw[$];   // {addr, way, data}
  logic [23:0] exp_tag[$];  // {way, tag}
  logic [33:0] exp_rd[$];   // {addr, len}
  logic [33:0] exp_wa[$];   // {addr, len}
  logic [36:0] exp_wb[$];   // {data, strb, last}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    if (bmem.exists(a[31:2])) return bmem[a[31:2]];
    return {a[31:2], 2'b01} ^ 32'h3C3C_5A5A;
  endfunction

  function automatic logic [31:0] sram_word(input logic [1:0] w, input logic [31:0] a);
    return (a ^ 32'h6B8B_4567) + {w, 30'h0};
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_w & ~m) | (new_w & m);
  endfunction

  task automatic flush_q();
    exp_resp.delete(); exp_lat.delete(); exp_cw.delete(); exp_tag.delete();
    exp_rd.delete(); exp_wa.delete(); exp_wb.delete();
  endtask

  // Reference behaviour: what the bus and the SRAM must see, and the response.
  task automatic issue(input logic [31:0] pa, input logic [1:0] way, input logic dirty,
                       input logic [31:0] victim, input logic unc, input logic st,
                       input logic [31:0] wd, input logic [3:0] sb);
    logic [31:0] line, vline, w;
    int b;
    line  = {pa[31:4], 4'h0};
    vline = {victim[31:4], 4'h0};
    if (unc && !st) begin
      exp_rd.push_back({pa, 2'd0});
      exp_resp.push_back(bmem_rd(pa));
    end else if (unc) begin
      exp_wa.push_back({pa, 2'd0});
      exp_wb.push_back({wd, sb, 1'b1});
      bmem[pa[31:2]] = apply_strb(bmem_rd(pa), wd, sb);
      exp_resp.push_back(32'h0);
    end else begin
      if (dirty) begin
        exp_wa.push_back({vline, 2'd3});
        for (int k = 0; k < 4; k++) begin
          w = sram_word(way, vline + 32'(4*k));
          exp_wb.push_back({w, 4'hF, k == 3});
          bmem[vline[31:2] + 30'(k)] = w;
        end
      end
      exp_rd.push_back({line, 2'd3});
      for (int k = 0; k < 4; k++) begin
        w = bmem_rd(line + 32'(4*k));
        if (st && k == int'(pa[3:2])) w = apply_strb(w, wd, sb);
        exp_cw.push_back({line + 32'(4*k), way, w});
      end
      exp_tag.push_back({way, pa[31:12], 1'b1, st});
      exp_resp.push_back(st ? 32'h0 : bmem_rd({pa[31:2], 2'b00}));
    end
    exp_lat.push_back(!zero_wait ? -1 : unc ? (st ? 4 : 3) : (dirty ? 18 : 7));

    @(posedge clk); #1;
    req_valid_i = 1'b1; req_paddr_i = pa; req_way_i = way; req_dirty_i = dirty;
    req_victim_addr_i = victim; req_uncached_i = unc; req_store_i = st;
    req_wdata_i = wd; req_strb_i = sb;
    b = 0;
    forever begin
      @(negedge clk);
      if (req_ready_o || b >= 50) break;
      b++;
      @(posedge clk); #1;
    end
    check("req_accept", req_ready_o, 1'b1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int b = 0;
    while (exp_resp.size() != 0 && b < 3000) begin
      @(posedge clk);
      b++;
    end
    if (exp_resp.size() != 0) begin
      check({nm, "_timeout"}, 1'b1, 1'b0);
      flush_q();
    end
    @(negedge clk);
    check({nm, "_leftover"}, exp_cw.size() + exp_tag.size() + exp_rd.size()
          + exp_wa.size() + exp_wb.size(), 0);
  endtask

  // Port-1 read model: data for the address/way of the previous cycle.
  initial begin
    logic [31:0] sa; logic [1:0] sw; bit act;
    cache_rdata_i = '0;
    forever begin
      @(negedge clk);
      sa = cache_addr_o; sw = cache_way_o;
      act = (cache_strb_o == 4'h0) && (sw != 2'b00) && !cache_tag_we_o;
      @(posedge clk); #1;
      cache_rdata_i = act ? sram_word(sw, sa) : 32'h0;
    end
  end

  // Bus read slave.
  initial begin
    bit hs; int beats, k; logic [31:0] base;
    rd_ready_i = 0; rd_valid_i = 0; rd_last_i = 0; rd_data_i = '0;
    @(posedge clk); #1;
    forever begin
      rd_ready_i = zero_wait || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      hs = rst_n && rd_req_o && rd_ready_i;
      base = rd_addr_o; beats = int'(rd_len_o) + 1;
      @(posedge clk); #1;
      rd_ready_i = 0;
      if (hs) begin
        k = 0;
        while (k < beats) begin
          if (!rst_n) break;
          if (zero_wait || $urandom_range(0, 3) != 0) begin
            rd_valid_i = 1; rd_data_i = bmem_rd(base + 32'(4*k)); rd_last_i = (k == beats - 1);
            k++;
          end else begin
            rd_valid_i = 0; rd_last_i = 0; rd_data_i = $urandom();
          end
          @(posedge clk); #1;
        end
        rd_valid_i = 0; rd_last_i = 0;
      end
    end
  end

  // Bus write slave.
  initial begin
    bit hs; int beats, nb, d;
    wr_ready_i = 0; wr_data_ready_i = 0; wr_done_i = 0;
    @(posedge clk); #1;
    forever begin
      wr_ready_i = zero_wait || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      hs = rst_n && wr_req_o && wr_ready_i;
      beats = int'(wr_len_o) + 1;
      @(posedge clk); #1;
      wr_ready_i = 0;
      if (hs) begin
        nb = 0;
        while (nb < beats && rst_n) begin
          wr_data_ready_i = zero_wait || ($urandom_range(0, 1) != 0);
          @(negedge clk);
          if (wr_data_valid_o && wr_data_ready_i) nb++;
          @(posedge clk); #1;
        end
        wr_data_ready_i = 0;
        d = zero_wait ? 0 : $urandom_range(0, 3);
        repeat (d) begin @(posedge clk); #1; end
        wr_done_i = rst_n;
        @(posedge clk); #1;
        wr_done_i = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents something.
  logic        stall_prev = 1'b0;
  logic [36:0] beat_prev  = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid_i && req_ready_o) acc_cyc = cyc;
      if (resp_valid_o) begin
        if (exp_resp.size() == 0) check("resp_unexpected", 1'b1, 1'b0);
        else begin
          int lat;
          lat = exp_lat.pop_front();
          check("resp_rdata", resp_rdata_o, exp_resp.pop_front());
          if (lat >= 0) check("resp_latency", cyc - acc_cyc, lat);
        end
      end
      if (cache_strb_o != 4'h0) begin
        if (exp_cw.size() == 0) check("sram_write_unexpected", 1'b1, 1'b0);
        else check("sram_write", {cache_addr_o, cache_way_o, cache_wdata_o, cache_strb_o},
                   {exp_cw.pop_front(), 4'hF});
      end
      if (cache_tag_we_o) begin
        if (exp_tag.size() == 0) check("tag_write_unexpected", 1'b1, 1'b0);
        else check("tag_write", {cache_way_o, cache_tag_data_o}, exp_tag.pop_front());
      end
      if (rd_req_o && rd_ready_i) begin
        if (exp_rd.size() == 0) check("rd_req_unexpected", 1'b1, 1'b0);
        else check("rd_req", {rd_addr_o, rd_len_o}, exp_rd.pop_front());
      end
      if (wr_req_o && wr_ready_i) begin
        if (exp_wa.size() == 0) check("wr_req_unexpected", 1'b1, 1'b0);
        else check("wr_req", {wr_addr_o, wr_len_o}, exp_wa.pop_front());
      end
      if (stall_prev) check("wr_beat_stable", {wr_data_valid_o, wr_data_o, wr_strb_o, wr_last_o},
                            {1'b1, beat_prev});
      if (wr_data_valid_o && wr_data_ready_i) begin
        if (exp_wb.size() == 0) check("wr_beat_unexpected", 1'b1, 1'b0);
        else check("wr_beat", {wr_data_o, wr_strb_o, wr_last_o}, exp_wb.pop_front());
      end
      stall_prev = wr_data_valid_o && !wr_data_ready_i;
      beat_prev  = {wr_data_o, wr_strb_o, wr_last_o};
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic logic any_output();
    return |{req_ready_o, resp_valid_o, resp_rdata_o, cache_addr_o, cache_way_o, cache_strb_o,
             cache_wdata_o, cache_tag_we_o, cache_tag_data_o, rd_req_o, rd_addr_o, rd_len_o,
             wr_req_o, wr_addr_o, wr_len_o, wr_data_valid_o, wr_data_o, wr_strb_o, wr_last_o};
  endfunction

  initial begin
    logic [31:0] pa, vic;
    int b;
    rst_n = 1'b0; req_valid_i = 0; req_paddr_i = '0; req_way_i = '0; req_dirty_i = 0;
    req_victim_addr_i = '0; req_uncached_i = 0; req_store_i = 0; req_wdata_i = '0; req_strb_i = '0;
    #3;
    check("reset_outputs", any_output(), 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", req_ready_o, 1'b1);
    check("reset_idle_quiet", {resp_valid_o, cache_way_o, cache_strb_o, cache_tag_we_o,
                               rd_req_o, wr_req_o, wr_data_valid_o}, '0);

    // Directed cases on a zero-wait bus.
    for (int k = 0; k < 4; k++) bmem[30'h0700_0010 + 30'(k)] = 32'hA0A0_0000 + 32'(k);
    issue(32'h1C00_0048, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    wait_done("clean_load_miss");

    for (int k = 0; k < 4; k++) bmem[30'h0000_0810 + 30'(k)] = 32'hB1B2_0000 + 32'(k);
    issue(32'h0000_2044, 2'b10, 1'b1, 32'h0800_1040, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    wait_done("dirty_store_miss");

    issue(32'hBFAF_8000, 2'b01, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1122_3344, 4'b1000);
    wait_done("uncached_store");

    issue(32'hBFAF_8000, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0);
    wait_done("uncached_load");

    issue(32'h0800_104C, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    wait_done("refill_after_wb");

    // Randomized traffic with bus stalls and write-data back-pressure.
    zero_wait = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pa  = {$urandom()} & 32'hFFFF_FFFC;
      vic = $urandom();
      if (vic[31:4] == pa[31:4]) vic[20] = ~vic[20];
      issue(pa, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, 1'($urandom_range(0, 1)), vic,
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom(),
            4'($urandom_range(1, 15)));
      wait_done("random");
    end

    // Reset in the middle of the third refill beat.
    zero_wait = 1'b1;
    issue(32'h3000_0104, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!(cache_strb_o != 4'h0 && cache_addr_o[3:2] == 2'd2) && b < 100);
    check("reset_beat2_reached", cache_addr_o[3:2], 2'd2);
    #1 rst_n = 1'b0;
    #1 check("midreset_outputs", any_output(), 1'b0);
    flush_q();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_ready", req_ready_o, 1'b1);
    issue(32'h3000_0108, 2'b10, 1'b1, 32'h4000_0020, 1'b0, 1'b0, 32'h0, 4'h0);
    wait_done("after_reset_request");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
